// File: rtl/frog_ride_ctrl_pkg.sv
// ============================================================================
// Module      : frogger_pkg
// Description : Shared enums, screen constants and score helper for the frog.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package frogger_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } hop_dir_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOP      = 3'd1,
    ST_LAND     = 3'd2,
    ST_DYING    = 3'd3,
    ST_GAMEOVER = 3'd4
  } frog_state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int FROG_SIDE = 40;
  localparam int X_MAX     = SCREEN_W - FROG_SIDE;
  localparam int COORD_W   = 11;
  localparam int SCORE_W   = 10;
  localparam int SCORE_MAX = 999;

  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] s,
                                                   input logic [4:0]         inc);
    logic [SCORE_W:0] sum;
    sum = (SCORE_W+1)'(s) + (SCORE_W+1)'(inc);
    return (sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/frog_ride_ctrl_if.sv
// ============================================================================
// Module      : frog_ride_ctrl_if
// Description : Hop handshake, lilypad vectors and frog status bundle.
//               FROG_SCORE_EN adds the Score field.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface frog_ride_ctrl_if #(
  parameter int N_PADS = 6
);
  logic              Hop_Valid;
  logic [1:0]        Hop_Dir;
  logic              Hop_Ready;
  logic [N_PADS-1:0] LPad_Collision;
  logic [N_PADS-1:0] LPad_Move;
  logic [N_PADS-1:0] LPad_Dir;
  logic [10:0]       Frog_X;
  logic [10:0]       Frog_Y;
  logic              Frog_Dead;
  logic              Game_Over;
  logic [1:0]        Lives;
`ifdef FROG_SCORE_EN
  logic [9:0]        Score;

  modport master (
    output Hop_Valid, Hop_Dir, LPad_Collision, LPad_Move, LPad_Dir,
    input  Hop_Ready, Frog_X, Frog_Y, Frog_Dead, Game_Over, Lives, Score
  );
  modport slave (
    input  Hop_Valid, Hop_Dir, LPad_Collision, LPad_Move, LPad_Dir,
    output Hop_Ready, Frog_X, Frog_Y, Frog_Dead, Game_Over, Lives, Score
  );
`else
  modport master (
    output Hop_Valid, Hop_Dir, LPad_Collision, LPad_Move, LPad_Dir,
    input  Hop_Ready, Frog_X, Frog_Y, Frog_Dead, Game_Over, Lives
  );
  modport slave (
    input  Hop_Valid, Hop_Dir, LPad_Collision, LPad_Move, LPad_Dir,
    output Hop_Ready, Frog_X, Frog_Y, Frog_Dead, Game_Over, Lives
  );
`endif
endinterface

`default_nettype wire

// File: rtl/frog_ride_ctrl_lives.sv
// ============================================================================
// Module      : frog_lives_ctr
// Description : Lives counter with decrement and last-life detect.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frog_lives_ctr #(
  parameter int LIVES_INIT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dec_i,
  output logic [1:0] lives_o,
  output logic       last_o
);

  logic [1:0] lives_q, lives_d;

  always_comb begin
    lives_d = lives_q;
    if (dec_i && (lives_q != 2'd0)) lives_d = lives_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lives_q <= 2'(LIVES_INIT);
    else       lives_q <= lives_d;
  end

  assign lives_o = lives_q;
  assign last_o  = (lives_q == 2'd1);

endmodule

`default_nettype wire

// File: rtl/frog_ride_ctrl.sv
// ============================================================================
// Module      : frog_ride_ctrl
// Description : Frog position, hop sequencing, pad riding, death and lives.
//               FROG_SCORE_EN adds a saturating score counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frog_ride_ctrl
  import frogger_pkg::*;
#(
  parameter int N_PADS       = 6,
  parameter int START_X      = 300,
  parameter int START_Y      = 440,
  parameter int HOP_STEP     = 10,
  parameter int HOP_FRAMES   = 4,
  parameter int RIDE_STEP    = 10,
  parameter int WATER_Y_MIN  = 80,
  parameter int WATER_Y_MAX  = 240,
  parameter int GOAL_Y       = 40,
  parameter int DEATH_FRAMES = 30,
  parameter int LIVES_INIT   = 3
) (
  input  logic            frame_clk,
  input  logic            Reset,
  frog_ride_ctrl_if.slave bus
);

  localparam int HOP_DIST = HOP_STEP * HOP_FRAMES;
  localparam int Y_LIMIT  = (START_Y < SCREEN_H - FROG_SIDE) ? START_Y : SCREEN_H - FROG_SIDE;
  localparam int CNT_W    = 5;

  frog_state_t          state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  hop_dir_t             dir_q, dir_d;
  hop_dir_t             req_dir;
  logic                 hop_ok, in_water, any_col, sel_move, sel_dir, ride_oob;
  logic [COORD_W-1:0]   ride_x;
  logic                 lives_dec, lives_last;
  logic [1:0]           lives;
`ifdef FROG_SCORE_EN
  logic [SCORE_W-1:0]   score_q, score_d;
`endif

  frog_lives_ctr #(.LIVES_INIT(LIVES_INIT)) u_lives (
    .clk_i   (frame_clk),
    .rst_i   (Reset),
    .dec_i   (lives_dec),
    .lives_o (lives),
    .last_o  (lives_last)
  );

  // Bounds are tested against the un-moved coordinate so nothing can wrap.
  always_comb begin
    req_dir = hop_dir_t'(bus.Hop_Dir);
    hop_ok  = 1'b0;
    unique case (req_dir)
      DIR_UP:    hop_ok = (y_q >= COORD_W'(GOAL_Y + HOP_DIST));
      DIR_DOWN:  hop_ok = ({1'b0, y_q} + 12'(HOP_DIST)) <= 12'(Y_LIMIT);
      DIR_LEFT:  hop_ok = (x_q >= COORD_W'(HOP_DIST));
      DIR_RIGHT: hop_ok = ({1'b0, x_q} + 12'(HOP_DIST)) <= 12'(X_MAX);
      default:   hop_ok = 1'b0;
    endcase
  end

  always_comb begin
    in_water = (y_q >= COORD_W'(WATER_Y_MIN)) && (y_q <= COORD_W'(WATER_Y_MAX));
    any_col  = |bus.LPad_Collision;
    sel_move = 1'b0;
    sel_dir  = 1'b0;
    for (int i = N_PADS - 1; i >= 0; i--) begin
      if (bus.LPad_Collision[i]) begin
        sel_move = bus.LPad_Move[i];
        sel_dir  = bus.LPad_Dir[i];
      end
    end
    ride_oob = sel_dir ? (({1'b0, x_q} + 12'(RIDE_STEP)) > 12'(X_MAX))
                       : (x_q < COORD_W'(RIDE_STEP));
    ride_x   = sel_dir ? (x_q + COORD_W'(RIDE_STEP)) : (x_q - COORD_W'(RIDE_STEP));
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    lives_dec = 1'b0;
`ifdef FROG_SCORE_EN
    score_d   = score_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Hop_Valid && hop_ok) begin
          state_d = ST_HOP;
          cnt_d   = '0;
          dir_d   = req_dir;
`ifdef FROG_SCORE_EN
          if (req_dir == DIR_UP) score_d = score_add(score_q, 5'd1);
`endif
        end else if (in_water && !any_col) begin
          state_d = ST_DYING;
          cnt_d   = '0;
        end else if (in_water && sel_move) begin
          if (ride_oob) begin
            state_d = ST_DYING;
            cnt_d   = '0;
          end else begin
            x_d = ride_x;
          end
        end
      end
      ST_HOP: begin
        unique case (dir_q)
          DIR_UP:    y_d = y_q - COORD_W'(HOP_STEP);
          DIR_DOWN:  y_d = y_q + COORD_W'(HOP_STEP);
          DIR_LEFT:  x_d = x_q - COORD_W'(HOP_STEP);
          DIR_RIGHT: x_d = x_q + COORD_W'(HOP_STEP);
          default:   x_d = x_q;
        endcase
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(HOP_FRAMES - 1)) begin
          state_d = ST_LAND;
          cnt_d   = '0;
        end
      end
      ST_LAND: begin
        state_d = ST_IDLE;
        if (in_water && !any_col) begin
          state_d = ST_DYING;
          cnt_d   = '0;
        end else if (y_q == COORD_W'(GOAL_Y)) begin
          x_d = COORD_W'(START_X);
          y_d = COORD_W'(START_Y);
`ifdef FROG_SCORE_EN
          score_d = score_add(score_q, 5'd10);
`endif
        end
      end
      ST_DYING: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DEATH_FRAMES - 1)) begin
          cnt_d     = '0;
          lives_dec = 1'b1;
          if (lives_last) begin
            state_d = ST_GAMEOVER;
          end else begin
            state_d = ST_IDLE;
            x_d     = COORD_W'(START_X);
            y_d     = COORD_W'(START_Y);
          end
        end
      end
      ST_GAMEOVER: state_d = ST_GAMEOVER;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      x_q     <= COORD_W'(START_X);
      y_q     <= COORD_W'(START_Y);
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
`ifdef FROG_SCORE_EN
      score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef FROG_SCORE_EN
      score_q <= score_d;
`endif
    end
  end

  assign bus.Hop_Ready = (state_q == ST_IDLE);
  assign bus.Frog_Dead = (state_q == ST_DYING);
  assign bus.Game_Over = (state_q == ST_GAMEOVER);
  assign bus.Frog_X    = x_q;
  assign bus.Frog_Y    = y_q;
  assign bus.Lives     = lives;
`ifdef FROG_SCORE_EN
  assign bus.Score     = score_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frog_ride_ctrl.sv
// ============================================================================
// Module      : tb_frog_ride_ctrl
// Description : Directed bench with a rule-level game model for frog_ride_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_frog_ride_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   model_on = 1'b0;

  frog_ride_ctrl_if #(.N_PADS(6)) bus ();

  frog_ride_ctrl dut (
    .frame_clk (clk),
    .Reset     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model in plain integers: mode 0 idle, 1 hop, 2 land, 3 dying, 4 game over.
  int mx, my, ml, mode, left, hdir;

  always @(posedge clk) begin : p_model
    int tx, ty, idx;
    if (rst) begin
      mx = 300; my = 440; ml = 3; mode = 0; left = 0; hdir = 0;
    end else begin
      idx = -1;
      for (int i = 5; i >= 0; i--) if (bus.LPad_Collision[i]) idx = i;
      case (mode)
        0: begin
          tx = mx; ty = my;
          case (bus.Hop_Dir)
            2'd0: ty = my - 40;
            2'd1: ty = my + 40;
            2'd2: tx = mx - 40;
            default: tx = mx + 40;
          endcase
          if (bus.Hop_Valid && tx >= 0 && tx <= 600 && ty >= 40 && ty <= 440) begin
            mode = 1; hdir = int'(bus.Hop_Dir); left = 4;
          end else if (my >= 80 && my <= 240) begin
            if (idx < 0) begin
              mode = 3; left = 30;
            end else if (bus.LPad_Move[idx]) begin
              tx = mx + (bus.LPad_Dir[idx] ? 10 : -10);
              if (tx < 0 || tx > 600) begin mode = 3; left = 30; end
              else mx = tx;
            end
          end
        end
        1: begin
          case (hdir)
            0: my = my - 10;
            1: my = my + 10;
            2: mx = mx - 10;
            default: mx = mx + 10;
          endcase
          left--;
          if (left == 0) mode = 2;
        end
        2: begin
          if (my >= 80 && my <= 240 && idx < 0) begin mode = 3; left = 30; end
          else begin
            mode = 0;
            if (my == 40) begin mx = 300; my = 440; end
          end
        end
        3: begin
          left--;
          if (left == 0) begin
            ml--;
            if (ml == 0) mode = 4;
            else begin mode = 0; mx = 300; my = 440; end
          end
        end
        default: mode = 4;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_x",     int'(bus.Frog_X),    mx);
      check("m_y",     int'(bus.Frog_Y),    my);
      check("m_lives", int'(bus.Lives),     ml);
      check("m_ready", int'(bus.Hop_Ready), (mode == 0) ? 1 : 0);
      check("m_dead",  int'(bus.Frog_Dead), (mode == 3) ? 1 : 0);
      check("m_over",  int'(bus.Game_Over), (mode == 4) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hop(input int d);
    bus.Hop_Valid = 1'b1;
    bus.Hop_Dir   = 2'(d);
    tick(1);
    bus.Hop_Valid = 1'b0;
    tick(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Hop_Valid = 1'b0; bus.Hop_Dir = 2'd0;
    bus.LPad_Collision = '0; bus.LPad_Move = '0; bus.LPad_Dir = '0;
    tick(1);
    model_on = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_x", int'(bus.Frog_X), 300);
    check("rst_y", int'(bus.Frog_Y), 440);
    check("rst_lives", int'(bus.Lives), 3);
    check("rst_ready", int'(bus.Hop_Ready), 1);

    // Single hop up: 440 -> 400 over four frames, one LAND frame.
    bus.Hop_Valid = 1'b1; bus.Hop_Dir = 2'd0;
    tick(1);
    bus.Hop_Valid = 1'b0;
    check("hop_acc_y", int'(bus.Frog_Y), 440);
    check("hop_busy", int'(bus.Hop_Ready), 0);
    tick(1);
    check("hop_f1_y", int'(bus.Frog_Y), 430);
    tick(3);
    check("hop_f4_y", int'(bus.Frog_Y), 400);
    check("land_busy", int'(bus.Hop_Ready), 0);
    tick(1);
    check("hop_done", int'(bus.Hop_Ready), 1);

    // Land in water with no pad: drown.
    hop(0); hop(0); hop(0); hop(0);
    check("drown_y", int'(bus.Frog_Y), 240);
    check("drown_dead", int'(bus.Frog_Dead), 1);
    tick(29);
    check("drown_hold", int'(bus.Frog_Dead), 1);
    tick(1);
    check("drown_end", int'(bus.Frog_Dead), 0);
    check("drown_lives", int'(bus.Lives), 2);
    check("respawn_y", int'(bus.Frog_Y), 440);

    // Ride pad 2 rightward at Y=200.
    bus.LPad_Collision = 6'b000100; bus.LPad_Dir = 6'b000100;
    repeat (6) hop(0);
    check("ride_y", int'(bus.Frog_Y), 200);
    bus.LPad_Move = 6'b000100;
    tick(3);
    bus.LPad_Move = '0;
    check("ride_x30", int'(bus.Frog_X), 330);
    bus.LPad_Collision = 6'b000110; bus.LPad_Move = 6'b000110;
    tick(1);
    bus.LPad_Move = '0;
    check("ride_pad1", int'(bus.Frog_X), 320);

    // Ride to the right edge, then off it.
    bus.LPad_Collision = 6'b000100; bus.LPad_Move = 6'b000100;
    tick(28);
    check("edge_x", int'(bus.Frog_X), 600);
    tick(1);
    bus.LPad_Move = '0;
    check("edge_dead", int'(bus.Frog_Dead), 1);
    check("edge_hold_x", int'(bus.Frog_X), 600);
    bus.LPad_Collision = '0;
    tick(30);
    check("edge_lives", int'(bus.Lives), 1);
    check("edge_resp_x", int'(bus.Frog_X), 300);

    // Out-of-bounds hop is consumed and ignored.
    repeat (7) hop(2);
    check("left_x", int'(bus.Frog_X), 20);
    bus.Hop_Valid = 1'b1; bus.Hop_Dir = 2'd2;
    tick(1);
    bus.Hop_Valid = 1'b0;
    check("oob_x", int'(bus.Frog_X), 20);
    check("oob_ready", int'(bus.Hop_Ready), 1);

    // Hop beats ride in the same frame.
    bus.LPad_Collision = 6'b000100;
    repeat (5) hop(0);
    bus.Hop_Valid = 1'b1; bus.Hop_Dir = 2'd3; bus.LPad_Move = 6'b000100;
    tick(1);
    bus.Hop_Valid = 1'b0; bus.LPad_Move = '0;
    check("prio_x", int'(bus.Frog_X), 20);
    tick(5);
    check("prio_land_x", int'(bus.Frog_X), 60);
    check("prio_land_y", int'(bus.Frog_Y), 240);

    // Third death: game over, hops ignored.
    bus.LPad_Collision = '0;
    tick(1);
    check("d3_dead", int'(bus.Frog_Dead), 1);
    tick(30);
    check("go_lives", int'(bus.Lives), 0);
    check("go_flag", int'(bus.Game_Over), 1);
    check("go_ready", int'(bus.Hop_Ready), 0);
    hop(0);
    check("go_frozen_y", int'(bus.Frog_Y), 240);

    // Reset from game over, then reset mid-hop.
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst2_lives", int'(bus.Lives), 3);
    check("rst2_over", int'(bus.Game_Over), 0);
    check("rst2_x", int'(bus.Frog_X), 300);
    bus.Hop_Valid = 1'b1; bus.Hop_Dir = 2'd0;
    tick(1);
    bus.Hop_Valid = 1'b0;
    tick(2);
    check("midhop_y", int'(bus.Frog_Y), 420);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst3_y", int'(bus.Frog_Y), 440);
    check("rst3_ready", int'(bus.Hop_Ready), 1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
